// File: rtl/spi_master_seq_if.sv
// Host and SPI-master signal bundle for the byte sequencer.
// The slave modport is the sequencer's view; the master modport is the
// environment (host plus SPI master) that drives it.
interface spi_master_seq_if #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
);
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  // host side
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             tx_full;
  logic [TX_CW-1:0] tx_count;
  logic             rd_en;
  logic [7:0]       rd_data;
  logic             rx_empty;
  logic [RX_CW-1:0] rx_count;
  logic             busy;
  logic             rx_overflow;
  logic             timeout_err;
  logic             clr_err;

  // SPI master side
  logic             m_start;
  logic [7:0]       m_data_in;
  logic             m_cs;
  logic [7:0]       m_data_out;

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err, m_cs, m_data_out,
    output tx_full, tx_count, rd_data, rx_empty, rx_count, busy,
           rx_overflow, timeout_err, m_start, m_data_in
  );

  modport master (
    output wr_en, wr_data, rd_en, clr_err, m_cs, m_data_out,
    input  tx_full, tx_count, rd_data, rx_empty, rx_count, busy,
           rx_overflow, timeout_err, m_start, m_data_in
  );
endinterface

// File: rtl/spi_master_seq.sv
// Byte-stream sequencer in front of an SPI master: TX FIFO feeds one byte
// per transfer, cs tracks completion, received bytes land in an FWFT RX FIFO.
module spi_master_seq #(
  parameter int TX_DEPTH   = 4,
  parameter int RX_DEPTH   = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input logic              clk,
  input logic              rst,   // asynchronous, active low
  spi_master_seq_if.slave  bus
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_AW + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT_LOW, WAIT_HIGH, CAPTURE, GAP
  } state_t;

  state_t state_q, state_d;

  // TX FIFO
  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [TX_CW-1:0] tx_count_q;
  logic             tx_full, tx_push, tx_pop;

  // RX FIFO
  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [RX_CW-1:0] rx_count_q;
  logic             rx_full, rx_empty, rx_push, rx_pop;
  logic [7:0]       rd_hold_q;

  // FSM datapath registers
  logic             m_start_q, m_start_d;
  logic [7:0]       m_data_in_q, m_data_in_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             rx_ovf_q, rx_ovf_d, ovf_set;
  logic             to_err_q, to_err_d, to_set;

  assign tx_full  = (tx_count_q == TX_CW'(TX_DEPTH));
  assign tx_push  = bus.wr_en && !tx_full;
  assign tx_pop   = (state_q == LOAD);

  assign rx_full  = (rx_count_q == RX_CW'(RX_DEPTH));
  assign rx_empty = (rx_count_q == '0);
  assign rx_pop   = bus.rd_en && !rx_empty;

  // TX storage write (no reset so it maps onto RAM)
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= bus.wr_data;
  end

  // TX pointers and occupancy; pop only ever happens in LOAD, which is entered non-empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + TX_AW'(1);
      tx_count_q <= tx_count_q + TX_CW'(tx_push) - TX_CW'(tx_pop);
    end
  end

  // RX storage write; when full with a same-cycle pop this overwrites the slot being read out
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= bus.m_data_out;
  end

  // RX pointers, occupancy and the last-seen head used while empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      rd_hold_q   <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + RX_AW'(1);
      rx_count_q <= rx_count_q + RX_CW'(rx_push) - RX_CW'(rx_pop);
      if (!rx_empty) rd_hold_q <= rx_mem_q[rx_rd_ptr_q];
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      m_start_q   <= 1'b0;
      m_data_in_q <= '0;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      rx_ovf_q    <= 1'b0;
      to_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_start_q   <= m_start_d;
      m_data_in_q <= m_data_in_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      rx_ovf_q    <= rx_ovf_d;
      to_err_q    <= to_err_d;
    end
  end

  // Next-state logic, FIFO side effects and sticky flags (set beats clear)
  always_comb begin
    state_d     = state_q;
    m_start_d   = m_start_q;
    m_data_in_d = m_data_in_q;
    to_cnt_d    = to_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    ovf_set     = 1'b0;
    to_set      = 1'b0;
    rx_push     = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_count_q != '0) state_d = LOAD;
      end
      LOAD: begin
        m_data_in_d = tx_mem_q[tx_rd_ptr_q];
        m_start_d   = 1'b1;
        to_cnt_d    = '0;
        state_d     = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!bus.m_cs) begin
          m_start_d = 1'b0;
          state_d   = WAIT_HIGH;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          // master never answered: drop the byte and let the gap run
          m_start_d = 1'b0;
          to_set    = 1'b1;
          gap_cnt_d = '0;
          state_d   = GAP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (bus.m_cs) state_d = CAPTURE;
      end
      CAPTURE: begin
        // a host pop in this same cycle frees the slot we need
        if (!rx_full || rx_pop) rx_push = 1'b1;
        else                    ovf_set = 1'b1;
        gap_cnt_d = '0;
        state_d   = GAP;
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) state_d = IDLE;
        else                                     gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase

    rx_ovf_d = ovf_set | (rx_ovf_q & ~bus.clr_err);
    to_err_d = to_set  | (to_err_q & ~bus.clr_err);
  end

  assign bus.tx_full     = tx_full;
  assign bus.tx_count    = tx_count_q;
  assign bus.rx_empty    = rx_empty;
  assign bus.rx_count    = rx_count_q;
  assign bus.rd_data     = rx_empty ? rd_hold_q : rx_mem_q[rx_rd_ptr_q];
  assign bus.busy        = (state_q != IDLE);
  assign bus.rx_overflow = rx_ovf_q;
  assign bus.timeout_err = to_err_q;
  assign bus.m_start     = m_start_q;
  assign bus.m_data_in   = m_data_in_q;
endmodule

// File: tb/tb_spi_master_seq.sv
// Scoreboard bench for spi_master_seq: a behavioural SPI master/slave pair
// checks every transmitted byte, a monitor checks every host read.
module tb_spi_master_seq;
  localparam int TX_DEPTH   = 4;
  localparam int RX_DEPTH   = 4;
  localparam int GAP_CYCLES = 2;
  localparam int TIMEOUT    = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_master_seq_if #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) bus ();

  spi_master_seq #(
    .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH),
    .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] tx_exp [$];
  logic [7:0] rx_exp [$];

  bit         slave_en   = 1'b1;
  logic [7:0] slave_sr   = 8'h3C;
  logic [7:0] mdl_sent;
  bit         mdl_abort;
  int         mdl_gap    = 0;
  int         xfers_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SPI master + shift-register slave: returns the byte of the previous transfer
  initial begin
    bus.m_cs       = 1'b1;
    bus.m_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (slave_en && rst && bus.m_start) begin
        mdl_sent = bus.m_data_in;
        if (tx_exp.size() == 0) check("tx_expected_any", 32'(tx_exp.size()), 1);
        else                    check("tx_byte", mdl_sent, tx_exp.pop_front());
        if (xfers_done > 0) check("cs_high_gap_ge2", (mdl_gap >= 2), 1);
        bus.m_cs  = 1'b0;
        mdl_abort = 1'b0;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          if (!rst) mdl_abort = 1'b1;
          if (!mdl_abort) begin
            if (i == 0) check("m_start_single_pulse", bus.m_start, 0);
            check("m_data_in_stable", bus.m_data_in, mdl_sent);
          end
        end
        bus.m_data_out = slave_sr;
        $display("[TB] xfer sent=0x%02h returned=0x%02h%s", mdl_sent, slave_sr,
                 mdl_abort ? " (reset)" : "");
        slave_sr  = mdl_sent;
        bus.m_cs  = 1'b1;
        mdl_gap   = 0;
        xfers_done++;
      end else if (bus.m_cs) begin
        mdl_gap++;
      end
    end
  end

  // Monitor: every accepted host pop is compared with the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (rst && bus.rd_en && !bus.rx_empty) begin
        if (rx_exp.size() == 0) check("rx_expected_any", 32'(rx_exp.size()), 1);
        else begin
          $display("[TB] read rd_data=0x%02h", bus.rd_data);
          check("rx_byte", bus.rd_data, rx_exp.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    tick();
    bus.wr_en   = 1'b0;
    $display("[TB] write 0x%02h tx_count=%0d", b, bus.tx_count);
  endtask

  task automatic read_n(input int n, input int budget);
    int got = 0;
    int c   = 0;
    while (got < n && c < budget) begin
      bus.rd_en = !bus.rx_empty;
      tick();
      if (bus.rd_en) got++;
      c++;
    end
    bus.rd_en = 1'b0;
    check("reads_completed", got, n);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (!(bus.busy == 1'b0 && bus.tx_count == '0) && c < budget) begin
      tick();
      c++;
    end
    check("idle_reached", (c < budget), 1);
  endtask

  task automatic wait_cs(input logic lvl, input int budget);
    int c = 0;
    while (bus.m_cs !== lvl && c < budget) begin
      tick();
      c++;
    end
    check("cs_level_reached", bus.m_cs, lvl);
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_start"},     bus.m_start, 0);
    check({tag, "_busy"},        bus.busy, 0);
    check({tag, "_tx_count"},    bus.tx_count, 0);
    check({tag, "_rx_empty"},    bus.rx_empty, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int hi;
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.rd_en = 1'b0; bus.clr_err = 1'b0;

    // reset state
    repeat (3) tick();
    check_reset_outputs("rst");
    check("rst_m_data_in",   bus.m_data_in, 0);
    check("rst_rx_overflow", bus.rx_overflow, 0);
    check("rst_timeout_err", bus.timeout_err, 0);
    check("rst_tx_full",     bus.tx_full, 0);
    check("rst_rd_data",     bus.rd_data, 0);
    check("rst_rx_count",    bus.rx_count, 0);
    rst = 1'b1;
    tick();

    // single transfer, latency and FWFT read
    tx_exp.push_back(8'hA5);
    rx_exp.push_back(8'h3C);
    write_byte(8'hA5);
    tick();
    check("latency_m_start_low_after_1", bus.m_start, 0);
    tick();
    check("latency_m_start_high_after_2", bus.m_start, 1);
    check("m_data_in_loaded", bus.m_data_in, 8'hA5);
    wait_idle(100);
    check("t1_rx_count", bus.rx_count, 1);
    check("t1_rd_data", bus.rd_data, 8'h3C);
    check("t1_busy", bus.busy, 0);
    read_n(1, 20);
    check("t1_rd_data_holds", bus.rd_data, 8'h3C);

    // fill TX while a transfer is in flight; write while full is dropped
    tx_exp.push_back(8'h5A);
    write_byte(8'h5A);
    c = 0;
    while (!bus.m_start && c < 20) begin tick(); c++; end
    check("t2_started", bus.m_start, 1);
    for (int i = 1; i <= 4; i++) begin
      tx_exp.push_back(8'(i));
      write_byte(8'(i));
    end
    check("t2_tx_full", bus.tx_full, 1);
    check("t2_tx_count_full", bus.tx_count, 4);
    write_byte(8'hFF);
    check("t2_tx_count_after_drop", bus.tx_count, 4);
    foreach (rx_exp[i]) ;
    rx_exp.push_back(8'hA5); rx_exp.push_back(8'h5A); rx_exp.push_back(8'h01);
    rx_exp.push_back(8'h02); rx_exp.push_back(8'h03);
    read_n(5, 400);
    wait_idle(100);
    check("t2_no_overflow", bus.rx_overflow, 0);
    check("t2_rx_empty", bus.rx_empty, 1);

    // overflow: five transfers, no reads
    for (int i = 0; i < 4; i++) begin
      tx_exp.push_back(8'h10 + 8'(i));
      write_byte(8'h10 + 8'(i));
    end
    rx_exp.push_back(8'h04); rx_exp.push_back(8'h10);
    rx_exp.push_back(8'h11); rx_exp.push_back(8'h12);
    wait_idle(400);
    check("t3_rx_count_4", bus.rx_count, 4);
    check("t3_no_overflow_yet", bus.rx_overflow, 0);
    tx_exp.push_back(8'h14);
    write_byte(8'h14);
    wait_idle(100);
    check("t3_rx_count_kept", bus.rx_count, 4);
    check("t3_overflow_set", bus.rx_overflow, 1);
    check("t3_head_kept", bus.rd_data, 8'h04);
    pulse_clr();
    check("t3_overflow_cleared", bus.rx_overflow, 0);

    // RX full, pop in the CAPTURE cycle makes room
    tx_exp.push_back(8'h24);
    rx_exp.push_back(8'h14);
    write_byte(8'h24);
    wait_cs(1'b0, 40);
    wait_cs(1'b1, 40);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("t5_rx_count_stays", bus.rx_count, 4);
    check("t5_no_overflow", bus.rx_overflow, 0);
    wait_idle(100);
    read_n(4, 40);
    check("t5_rx_empty", bus.rx_empty, 1);

    // timeout: cs never falls
    slave_en = 1'b0;
    write_byte(8'h55);
    c = 0;
    while (!bus.m_start && c < 10) begin tick(); c++; end
    check("t4_started", bus.m_start, 1);
    check("t4_m_data_in", bus.m_data_in, 8'h55);
    hi = 0;
    while (bus.m_start && hi < 200) begin hi++; tick(); end
    check("t4_m_start_cycles", hi, TIMEOUT);
    check("t4_timeout_err", bus.timeout_err, 1);
    wait_idle(50);
    check("t4_busy", bus.busy, 0);
    check("t4_rx_count", bus.rx_count, 0);
    check("t4_timeout_sticky", bus.timeout_err, 1);
    pulse_clr();
    check("t4_timeout_cleared", bus.timeout_err, 0);
    slave_en = 1'b1;

    // asynchronous reset in WAIT_HIGH with two bytes queued
    tx_exp.push_back(8'h30);
    write_byte(8'h30);
    write_byte(8'h31);
    write_byte(8'h32);
    wait_cs(1'b0, 40);
    tick();
    check("t6_tx_queued", bus.tx_count, 2);
    check("t6_busy_before", bus.busy, 1);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    repeat (15) tick();
    rst = 1'b1;
    repeat (10) tick();
    check_reset_outputs("t6_after");
    check("t6_rx_count", bus.rx_count, 0);

    check("tx_scoreboard_drained", tx_exp.size(), 0);
    check("rx_scoreboard_drained", rx_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
